// File: rtl/guvm_data_mem_responder.sv
// Responder end of the core data port: req/gnt/rvalid handshake, byte-enabled word
// array, fixed-latency in-order responses, outstanding limit and protocol watchdog.
module guvm_data_mem_responder #(
    parameter int unsigned MEM_WORDS       = 1024,
    parameter logic [31:0] BASE_ADDR       = 32'h0000_0000,
    parameter int unsigned GNT_WAIT        = 0,
    parameter int unsigned RESP_LATENCY    = 1,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        data_req_i,
    output logic        data_gnt_o,
    input  logic [31:0] data_addr_i,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_wdata_i,
    output logic        data_rvalid_o,
    output logic [31:0] data_rdata_o,
    output logic        data_err_o,
    input  logic        stall_i,
    output logic        viol_o
);

    localparam int IW = $clog2(MEM_WORDS);
    localparam int CW = $clog2(GNT_WAIT + 2);
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [32:0]   SPAN      = 33'(MEM_WORDS) << 2;
    localparam logic [CW-1:0] WAIT_INIT = CW'((GNT_WAIT > 0) ? GNT_WAIT - 1 : 0);
    localparam logic [OW-1:0] MAX_O     = OW'(MAX_OUTSTANDING);

    typedef enum logic {S_IDLE, S_WAIT} state_e;

    logic [31:0] mem_q [MEM_WORDS];

    state_e        state_q, state_d;
    logic [CW-1:0] wcnt_q, wcnt_d;
    logic [31:0]   hold_addr_q, hold_wdata_q;
    logic          hold_we_q;
    logic [3:0]    hold_be_q;
    logic          hold_load, viol_set, viol_q;
    logic [OW-1:0] out_cnt_q;

    logic [RESP_LATENCY-1:0]        vld_pipe_q;
    logic [RESP_LATENCY-1:0]        err_pipe_q;
    logic [RESP_LATENCY-1:0][31:0]  rdata_pipe_q;

    logic          gnt, accept, retire, room, in_range, req_changed;
    logic [31:0]   offset, rd_word;
    logic [IW-1:0] widx;

    // Offset compare covers both bounds at once: addresses below BASE_ADDR wrap huge.
    assign offset   = data_addr_i - BASE_ADDR;
    assign in_range = ({1'b0, offset} < SPAN);
    assign widx     = IW'(offset >> 2);

    assign retire = vld_pipe_q[RESP_LATENCY-1];
    assign room   = (out_cnt_q < MAX_O) || retire;
    assign accept = data_req_i && gnt;

    assign req_changed = (data_addr_i != hold_addr_q) || (data_we_i != hold_we_q) ||
                         (data_be_i != hold_be_q) || (data_wdata_i != hold_wdata_q);

    always_comb begin
        state_d   = state_q;
        wcnt_d    = wcnt_q;
        gnt       = 1'b0;
        hold_load = 1'b0;
        viol_set  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (GNT_WAIT == 0) begin
                    gnt = data_req_i && room && !stall_i;
                end else if (data_req_i && !stall_i) begin
                    state_d   = S_WAIT;
                    wcnt_d    = WAIT_INIT;
                    hold_load = 1'b1;
                end
            end
            S_WAIT: begin
                if (!data_req_i) begin
                    state_d  = S_IDLE;
                    viol_set = 1'b1;
                end else if (req_changed) begin
                    viol_set  = 1'b1;
                    wcnt_d    = WAIT_INIT;
                    hold_load = 1'b1;
                end else if (wcnt_q == '0) begin
                    gnt = room && !stall_i;
                    if (gnt) state_d = S_IDLE;
                end else if (!stall_i) begin
                    wcnt_d = wcnt_q - 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (!rst_ni) gnt = 1'b0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= S_IDLE;
            wcnt_q       <= '0;
            hold_addr_q  <= '0;
            hold_we_q    <= 1'b0;
            hold_be_q    <= '0;
            hold_wdata_q <= '0;
            viol_q       <= 1'b0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            if (hold_load) begin
                hold_addr_q  <= data_addr_i;
                hold_we_q    <= data_we_i;
                hold_be_q    <= data_be_i;
                hold_wdata_q <= data_wdata_i;
            end
            if (viol_set) viol_q <= 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_cnt_q <= '0;
        end else if (accept && !retire) begin
            out_cnt_q <= out_cnt_q + 1'b1;
        end else if (retire && !accept) begin
            out_cnt_q <= out_cnt_q - 1'b1;
        end
    end

    // Read data is taken from the array before this edge's update; a single
    // accept is either a read or a write, so there is no same-edge hazard.
    assign rd_word = (accept && !data_we_i && in_range) ? mem_q[widx] : '0;

    always_ff @(posedge clk_i) begin
        if (accept && data_we_i && in_range) begin
            for (int n = 0; n < 4; n++) begin
                if (data_be_i[n]) mem_q[widx][8*n +: 8] <= data_wdata_i[8*n +: 8];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vld_pipe_q   <= '0;
            err_pipe_q   <= '0;
            rdata_pipe_q <= '0;
        end else begin
            vld_pipe_q[0]   <= accept;
            err_pipe_q[0]   <= accept && !in_range;
            rdata_pipe_q[0] <= rd_word;
            for (int i = 1; i < RESP_LATENCY; i++) begin
                vld_pipe_q[i]   <= vld_pipe_q[i-1];
                err_pipe_q[i]   <= err_pipe_q[i-1];
                rdata_pipe_q[i] <= rdata_pipe_q[i-1];
            end
        end
    end

    assign data_gnt_o    = gnt;
    assign data_rvalid_o = vld_pipe_q[RESP_LATENCY-1];
    assign data_rdata_o  = rdata_pipe_q[RESP_LATENCY-1];
    assign data_err_o    = err_pipe_q[RESP_LATENCY-1];
    assign viol_o        = viol_q;

endmodule

// File: tb/tb_guvm_data_mem_responder.sv
// Directed bench: three responder instances (default, grant wait, deep latency)
// share the request payload; each has its own req so they are exercised one at a time.
module tb_guvm_data_mem_responder;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic [31:0] addr = '0, wdata = '0;
    logic        we = 1'b0, stall = 1'b0;
    logic [3:0]  be = '0;
    logic        req_a = 1'b0, req_b = 1'b0, req_c = 1'b0;

    logic        gnt_a, rv_a, err_a, viol_a;
    logic        gnt_b, rv_b, err_b, viol_b;
    logic        gnt_c, rv_c, err_c, viol_c;
    logic [31:0] rd_a, rd_b, rd_c;

    int n_chk = 0, n_fail = 0;

    always #5 clk = ~clk;

    guvm_data_mem_responder u_a (
        .clk_i(clk), .rst_ni(rst_n), .data_req_i(req_a), .data_gnt_o(gnt_a),
        .data_addr_i(addr), .data_we_i(we), .data_be_i(be), .data_wdata_i(wdata),
        .data_rvalid_o(rv_a), .data_rdata_o(rd_a), .data_err_o(err_a),
        .stall_i(stall), .viol_o(viol_a)
    );

    guvm_data_mem_responder #(.GNT_WAIT(2)) u_b (
        .clk_i(clk), .rst_ni(rst_n), .data_req_i(req_b), .data_gnt_o(gnt_b),
        .data_addr_i(addr), .data_we_i(we), .data_be_i(be), .data_wdata_i(wdata),
        .data_rvalid_o(rv_b), .data_rdata_o(rd_b), .data_err_o(err_b),
        .stall_i(stall), .viol_o(viol_b)
    );

    guvm_data_mem_responder #(.RESP_LATENCY(3), .MAX_OUTSTANDING(2)) u_c (
        .clk_i(clk), .rst_ni(rst_n), .data_req_i(req_c), .data_gnt_o(gnt_c),
        .data_addr_i(addr), .data_we_i(we), .data_be_i(be), .data_wdata_i(wdata),
        .data_rvalid_o(rv_c), .data_rdata_o(rd_c), .data_err_o(err_c),
        .stall_i(stall), .viol_o(viol_c)
    );

    always @(negedge clk) begin
        if (rst_n) assert (u_c.out_cnt_q <= 2) else $error("outstanding count out of bounds: %0d", u_c.out_cnt_q);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic drive(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
        we = w; addr = a; wdata = d; be = b;
    endtask

    initial begin
        logic [31:0] c_addr [4];
        logic [31:0] c_data [4];
        c_addr = '{32'h0, 32'h4, 32'h8, 32'h10};
        c_data = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'hCAFE_F00D};

        // Reset state, with a request pending so grant gating is visible
        req_a = 1'b1;
        drive(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF);
        smp();
        chk("rst gnt",    gnt_a,  0);
        chk("rst rvalid", rv_a,   0);
        chk("rst rdata",  rd_a,   0);
        chk("rst err",    err_a,  0);
        chk("rst viol",   viol_a, 0);
        chk("rst rvalid c", rv_c, 0);
        nxt();
        rst_n = 1'b1;

        // 1: full-word write then read back
        smp();
        chk("t1 wr gnt", gnt_a, 1);
        nxt();
        drive(1'b0, 32'h10, 32'h0, 4'hF);
        smp();
        chk("t1 wr rvalid", rv_a, 1);
        chk("t1 wr err",    err_a, 0);
        chk("t1 wr rdata",  rd_a, 0);
        chk("t1 rd gnt",    gnt_a, 1);
        nxt();
        req_a = 1'b0;
        smp();
        chk("t1 rd rvalid", rv_a, 1);
        chk("t1 rd rdata",  rd_a, 32'hDEAD_BEEF);
        chk("t1 rd err",    err_a, 0);
        nxt();

        // 2: single-lane write; read with partial be returns the full word
        req_a = 1'b1;
        drive(1'b1, 32'h10, 32'h0000_AB00, 4'b0010);
        nxt();
        drive(1'b0, 32'h10, 32'h0, 4'b0001);
        nxt();
        req_a = 1'b0;
        smp();
        chk("t2 rd rvalid", rv_a, 1);
        chk("t2 rd rdata",  rd_a, 32'hDEAD_ABEF);
        nxt();

        // 5: out-of-range write errors and does not alias onto word 0
        req_a = 1'b1;
        drive(1'b1, 32'h0, 32'hA5A5_A5A5, 4'hF);
        nxt();
        drive(1'b1, 32'h1000, 32'h1234_5678, 4'hF);
        smp();
        chk("t5 oor gnt", gnt_a, 1);
        nxt();
        drive(1'b0, 32'h0, 32'h0, 4'hF);
        smp();
        chk("t5 oor rvalid", rv_a, 1);
        chk("t5 oor err",    err_a, 1);
        chk("t5 oor rdata",  rd_a, 0);
        nxt();
        drive(1'b0, 32'h10, 32'h0, 4'hF);
        smp();
        chk("t5 rd0 rdata", rd_a, 32'hA5A5_A5A5);
        chk("t5 rd0 err",   err_a, 0);
        nxt();
        req_a = 1'b0;
        smp();
        chk("t5 rd10 rdata", rd_a, 32'hDEAD_ABEF);
        chk("t5 rd10 err",   err_a, 0);
        nxt();

        // 3: grant wait of 2, then with a stall, then an abandoned request
        req_b = 1'b1;
        drive(1'b1, 32'h20, 32'h1, 4'hF);
        smp(); chk("t3 c0 gnt", gnt_b, 0); nxt();
        smp(); chk("t3 c1 gnt", gnt_b, 0); nxt();
        smp(); chk("t3 c2 gnt", gnt_b, 1); nxt();
        req_b = 1'b0;
        smp(); chk("t3 rvalid", rv_b, 1); nxt();

        req_b = 1'b1;
        smp(); chk("t3s c0 gnt", gnt_b, 0); nxt();
        stall = 1'b1;
        smp(); chk("t3s c1 gnt", gnt_b, 0); nxt();
        stall = 1'b0;
        smp(); chk("t3s c2 gnt", gnt_b, 0); nxt();
        smp(); chk("t3s c3 gnt", gnt_b, 1); nxt();
        req_b = 1'b0;
        nxt();

        smp(); chk("t3v viol before", viol_b, 0);
        req_b = 1'b1;
        nxt();
        req_b = 1'b0;
        smp(); chk("t3v c1 gnt", gnt_b, 0); nxt();
        smp();
        chk("t3v viol",   viol_b, 1);
        chk("t3v rvalid", rv_b, 0);
        nxt();

        // 4: preload instance c, then three back-to-back reads against a limit of 2
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, c_addr[i], c_data[i], 4'hF);
            req_c = 1'b1;
            nxt();
            req_c = 1'b0;
            repeat (3) nxt();
        end
        drive(1'b0, 32'h0, 32'h0, 4'hF);
        req_c = 1'b1;
        smp(); chk("t4 c0 gnt", gnt_c, 1); nxt();
        drive(1'b0, 32'h4, 32'h0, 4'hF);
        smp(); chk("t4 c1 gnt", gnt_c, 1); nxt();
        drive(1'b0, 32'h8, 32'h0, 4'hF);
        smp();
        chk("t4 c2 gnt",    gnt_c, 0);
        chk("t4 c2 rvalid", rv_c, 0);
        nxt();
        smp();
        chk("t4 c3 gnt",    gnt_c, 1);
        chk("t4 c3 rvalid", rv_c, 1);
        chk("t4 c3 rdata",  rd_c, 32'h1111_1111);
        nxt();
        req_c = 1'b0;
        smp();
        chk("t4 c4 rvalid", rv_c, 1);
        chk("t4 c4 rdata",  rd_c, 32'h2222_2222);
        nxt();
        smp(); chk("t4 c5 rvalid", rv_c, 0); nxt();
        smp();
        chk("t4 c6 rvalid", rv_c, 1);
        chk("t4 c6 rdata",  rd_c, 32'h3333_3333);
        nxt();

        // 6: reset with reads in flight
        drive(1'b0, 32'h0, 32'h0, 4'hF);
        req_c = 1'b1;
        nxt();
        drive(1'b0, 32'h4, 32'h0, 4'hF);
        nxt();
        req_c = 1'b0;
        nxt();
        smp();
        chk("t6 rvalid before rst", rv_c, 1);
        #1 rst_n = 1'b0;
        #1 chk("t6 rvalid in rst", rv_c, 0);
        nxt();
        nxt();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            smp();
            chk("t6 no rvalid after rst", rv_c, 0);
            nxt();
        end
        drive(1'b0, 32'h10, 32'h0, 4'hF);
        req_c = 1'b1;
        smp(); chk("t6 c0 gnt", gnt_c, 1); nxt();
        smp(); chk("t6 c1 gnt", gnt_c, 1); nxt();
        req_c = 1'b0;
        nxt();
        smp();
        chk("t6 rvalid", rv_c, 1);
        chk("t6 rdata",  rd_c, 32'hCAFE_F00D);
        nxt();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/guvm_data_mem_responder.md
Name: guvm_data_mem_responder

Overview:
- Synthesizable responder (slave) end of the core data memory interface (req/gnt/rvalid protocol).
- Sits opposite the core's data port in the GUVM bench.
- Accepts core requests and performs byte-enabled writes into an internal word array.
- Returns in-order read data/acks with a configurable grant wait and response latency.
- Flags out-of-range accesses and protocol violations.

Parameters:
- MEM_WORDS, 1024, number of 32-bit words in the array (power of 2).
- BASE_ADDR, 32'h0000_0000, byte address of word 0.
- GNT_WAIT, 0, cycles a request is held before grant (0 = same-cycle grant).
- RESP_LATENCY, 1, cycles from accepting edge to rvalid (>=1).
- MAX_OUTSTANDING, 2, accepted-but-unanswered request limit (>=1).

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset; asynchronous, active-low.
- data_req_i  in  1  core request.
- data_gnt_o  out  1  address-phase grant.
- data_addr_i  in  32  byte address.
- data_we_i  in  1  1 = write.
- data_be_i  in  4  byte enables, lane n = bits 8n+7:8n.
- data_wdata_i  in  32  write data.
- data_rvalid_o  out  1  response valid, one cycle per accepted request.
- data_rdata_o  out  32  read data; 0 for writes and errors.
- data_err_o  out  1  response error, qualified by rvalid.
- stall_i  in  1  bench-injected wait state; blocks grant and freezes the wait counter.
- viol_o  out  1  sticky protocol-violation flag.

Behaviour:
- Reset values:
  - gnt=0, rvalid=0, rdata=0, err=0, viol=0.
  - Outstanding count = 0, response pipeline empty, FSM = IDLE.
  - Array contents are not reset.
- Accept: occurs at a rising edge where req && gnt.
  - Address, we, be and wdata are sampled at that edge.
- In range: BASE_ADDR <= addr < BASE_ADDR + 4*MEM_WORDS; word index = (addr - BASE_ADDR) >> 2; addr[1:0] ignored.
- Write accept, in range: each lane with be=1 is updated at the accepting edge. Response: rdata=0, err=0.
- Read accept, in range: array word captured at the accepting edge, so reads always see any earlier-accepted write. be is ignored; the full word is returned.
- Out of range: no array write. Response: err=1, rdata=0.
- Response pipeline:
  - RESP_LATENCY-stage delay line of {valid, rdata, err}.
  - An entry accepted at edge k is presented with data_rvalid_o=1 during the cycle after edge k+RESP_LATENCY-1 (L=1 gives rvalid the cycle after the grant).
  - Responses are strictly in order; there is no backpressure on rvalid.
- Outstanding counter:
  - +1 on accept, -1 on rvalid retire; unchanged when both happen in the same cycle.
  - room = (count < MAX_OUTSTANDING) || retire this cycle.
- Grant FSM:
  - IDLE, GNT_WAIT==0: gnt = req && room && !stall_i, combinational, same cycle.
  - IDLE, GNT_WAIT>0: req && !stall_i goes to WAIT with cnt = GNT_WAIT-1, gnt=0.
  - WAIT: cnt decrements each cycle when !stall_i. While cnt==0, gnt = req && room && !stall_i. The grant edge returns to IDLE.
  - WAIT, req low: return to IDLE and set viol_o.
  - WAIT, addr/we/be/wdata changed vs the first WAIT cycle: set viol_o, restart wait with the new values.
- Simultaneous accept and retire in one cycle: both take effect.
- Reset mid-operation:
  - Pipeline is flushed immediately (rvalid drops asynchronously).
  - Nothing in flight ever responds after release.
  - Any write accepted before reset remains in the array.
- Count never exceeds MAX_OUTSTANDING or underflows; an assertion is provided in the bench.

Test Plan:
1. Defaults (GNT_WAIT=0, L=1). Write 0xDEADBEEF @0x10, be=1111 -> gnt same cycle, rvalid next cycle, err=0. Then read @0x10 -> rdata=0xDEADBEEF one cycle after grant.
2. Byte enables. Write 0x0000AB00 @0x10, be=0010 -> read @0x10 returns 0xDEADABEF. A read with be=0001 still returns the full 0xDEADABEF.
3. Grant wait. GNT_WAIT=2, req held from cycle 0 -> gnt in cycle 2. With stall_i=1 in cycle 1 -> gnt in cycle 3. Dropping req in cycle 1 -> viol_o=1 and no accept.
4. Outstanding limit. L=3, MAX_OUTSTANDING=2, back-to-back reads @0x0,0x4,0x8 -> accepts at cycles 0 and 1; third gnt withheld in cycle 2; granted in cycle 3 together with the first rvalid. rvalid in cycles 3,4,6 in order.
5. Out of range. MEM_WORDS=1024, write 0x12345678 @0x0000_1000 -> rvalid with err=1, rdata=0. Read @0x0 is unchanged. An in-range read follows with err=0.
6. Reset with two reads in flight (L=3) -> rvalid=0 immediately; no rvalid for 5 cycles after release; count=0; a prior write @0x10 is still readable.
